// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store controller: RV32I funct3 codes,
// access-size fields, FSM states and completion error codes.
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_RDATA = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Loads reject 011/110/111; stores accept only byte, half and word.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we)
      return f3[2] || (f3[1:0] == 2'b11);
    else
      return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data-path helper: legality/alignment check, byte strobes,
// store-lane replication and load byte/half extraction with extension.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        illegal,
  output logic        misaligned,
  output logic [3:0]  strb,
  output logic [31:0] bus_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  rd_lane [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign illegal    = f3_illegal(we, funct3);
  assign misaligned = ((funct3[1:0] == SZ_H) && addr_lo[0]) ||
                      ((funct3[1:0] == SZ_W) && (addr_lo != 2'b00));

  // Each byte lane carries the byte, the matching half of the halfword, or its own word byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam int HOFF = (gi % 2) * 8;
      assign bus_wdata[gi*8 +: 8] = (funct3[1:0] == SZ_B) ? wdata[7:0] :
                                    (funct3[1:0] == SZ_H) ? wdata[HOFF +: 8] :
                                                            wdata[gi*8 +: 8];
      assign rd_lane[gi] = rdata[gi*8 +: 8];
    end
  endgenerate

  assign ld_byte = rd_lane[addr_lo];
  assign ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    strb = 4'b0000;
    if (we) begin
      case (funct3)
        F3_SB:   strb = 4'b0001 << addr_lo;
        F3_SH:   strb = 4'b0011 << addr_lo;
        F3_SW:   strb = 4'b1111;
        default: strb = 4'b0000;
      endcase
    end
  end

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      F3_LW:   load_data = rdata;
      F3_LBU:  load_data = {24'h0, ld_byte};
      F3_LHU:  load_data = {16'h0, ld_half};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one decoded access, runs a valid/ready bus
// transaction, returns extended load data and reports errors/timeouts.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [1:0]  o_err,
  output logic [31:0] o_rdata,
  output logic        o_bus_valid,
  input  logic        i_bus_ready,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_strb,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

  state_t           state_reg;
  logic             we_reg;
  logic [2:0]       funct3_reg;
  logic [1:0]       addr_lo_reg;
  logic [1:0]       err_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      rdata_reg;
  logic             bus_valid_reg;
  logic             bus_we_reg;
  logic [31:0]      bus_addr_reg;
  logic [31:0]      bus_wdata_reg;
  logic [3:0]       bus_strb_reg;

  logic        in_idle;
  logic        al_we;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic        al_illegal;
  logic        al_misaligned;
  logic [3:0]  al_strb;
  logic [31:0] al_wdata;
  logic [31:0] al_load_data;

  // In IDLE the checker looks at the live request; afterwards at the captured one.
  assign in_idle    = (state_reg == ST_IDLE);
  assign al_we      = in_idle ? i_we           : we_reg;
  assign al_funct3  = in_idle ? i_funct3       : funct3_reg;
  assign al_addr_lo = in_idle ? i_addr[1:0]    : addr_lo_reg;

  lsu_align u_align (
    .we         (al_we),
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .wdata      (i_wdata),
    .rdata      (i_bus_rdata),
    .illegal    (al_illegal),
    .misaligned (al_misaligned),
    .strb       (al_strb),
    .bus_wdata  (al_wdata),
    .load_data  (al_load_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      we_reg        <= 1'b0;
      funct3_reg    <= '0;
      addr_lo_reg   <= '0;
      err_reg       <= ERR_OK;
      cnt_reg       <= '0;
      rdata_reg     <= '0;
      bus_valid_reg <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_strb_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_req) begin
            we_reg      <= i_we;
            funct3_reg  <= i_funct3;
            addr_lo_reg <= i_addr[1:0];
            if (al_illegal) begin
              err_reg   <= ERR_ILLEGAL;
              rdata_reg <= '0;
              state_reg <= ST_RESP;
            end else if (al_misaligned) begin
              err_reg   <= ERR_MISALIGN;
              rdata_reg <= '0;
              state_reg <= ST_RESP;
            end else begin
              err_reg       <= ERR_OK;
              cnt_reg       <= '0;
              bus_valid_reg <= 1'b1;
              bus_we_reg    <= i_we;
              bus_addr_reg  <= {i_addr[31:2], 2'b00};
              bus_wdata_reg <= i_we ? al_wdata : 32'h0;
              bus_strb_reg  <= al_strb;
              state_reg     <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (i_bus_ready) begin
            bus_valid_reg <= 1'b0;
            if (we_reg) begin
              rdata_reg <= '0;
              state_reg <= ST_RESP;
            end else begin
              cnt_reg   <= '0;
              state_reg <= ST_RDATA;
            end
          end else if (cnt_reg == CNT_LIM) begin
            bus_valid_reg <= 1'b0;
            err_reg       <= ERR_TIMEOUT;
            rdata_reg     <= '0;
            state_reg     <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_RDATA: begin
          if (i_bus_rvalid) begin
            rdata_reg <= al_load_data;
            state_reg <= ST_RESP;
          end else if (cnt_reg == CNT_LIM) begin
            err_reg   <= ERR_TIMEOUT;
            rdata_reg <= '0;
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_stall     = (i_req && in_idle) || (state_reg == ST_ADDR) || (state_reg == ST_RDATA);
  assign o_done      = (state_reg == ST_RESP);
  assign o_err       = o_done ? err_reg : ERR_OK;
  assign o_rdata     = rdata_reg;
  assign o_bus_valid = bus_valid_reg;
  assign o_bus_we    = bus_we_reg;
  assign o_bus_addr  = bus_addr_reg;
  assign o_bus_wdata = bus_wdata_reg;
  assign o_bus_strb  = bus_strb_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scenario bench for lsu_ctrl with TIMEOUT=4: expected err/rdata are queued
// when a request is driven and popped when o_done arrives.
module tb_lsu_ctrl;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [1:0]  err;
  logic [31:0] rdata;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_we         (we),
    .i_funct3     (funct3),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_stall      (stall),
    .o_done       (done),
    .o_err        (err),
    .o_rdata      (rdata),
    .o_bus_valid  (bus_valid),
    .i_bus_ready  (bus_ready),
    .o_bus_we     (bus_we),
    .o_bus_addr   (bus_addr),
    .o_bus_wdata  (bus_wdata),
    .o_bus_strb   (bus_strb),
    .i_bus_rvalid (bus_rvalid),
    .i_bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total_cnt);
    $fatal(1, "watchdog");
  end

  // One request; inputs change 1 ns after a rising edge, so that cycle is T0.
  task automatic run_op(input string name, input logic op_we, input logic [2:0] op_f3,
                        input logic [31:0] op_addr, input logic [31:0] op_wdata,
                        input int ready_wait, input int rvalid_wait, input logic [31:0] rd_word,
                        input logic [3:0] exp_strb, input logic [31:0] exp_bwdata,
                        input int exp_valid, input int exp_lat,
                        input logic [1:0] exp_err, input logic [31:0] exp_rdata);
    exp_t        e;
    exp_t        got;
    logic [31:0] exp_baddr;
    int          cyc, vcnt, rcnt, stall_cnt;
    bit          hs, in_rd, fin;
    e.err = exp_err;
    e.rdata = exp_rdata;
    exp_baddr = {op_addr[31:2], 2'b00};
    @(posedge clk);
    #1;
    req = 1'b1; we = op_we; funct3 = op_f3; addr = op_addr; wdata = op_wdata;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'hBAD0_BAD0;
    exp_q.push_back(e);
    cyc = 0; vcnt = 0; rcnt = 0; stall_cnt = 0; hs = 0; in_rd = 0; fin = 0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (hs) begin
        in_rd = !op_we;
        hs = 0;
      end
      if (done) begin
        fin = 1;
        bus_ready = 1'b0;
        bus_rvalid = 1'b0;
        got = exp_q.pop_front();
        total_cnt++;
        if (err !== got.err) $display("FAIL %s err: got %0d want %0d", name, err, got.err);
        else pass_cnt++;
        total_cnt++;
        if (rdata !== got.rdata) $display("FAIL %s rdata: got %h want %h", name, rdata, got.rdata);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== exp_lat) $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cnt, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (vcnt !== exp_valid) $display("FAIL %s valid_cycles: got %0d want %0d", name, vcnt, exp_valid);
        else pass_cnt++;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL %s stall_in_resp: got %b want 0", name, stall);
        else pass_cnt++;
        $display("txn %-14s we=%0d f3=%0d addr=%h err=%0d rdata=%h stall=%0d valid=%0d",
                 name, op_we, op_f3, op_addr, err, rdata, stall_cnt, vcnt);
      end else begin
        if (stall) stall_cnt++;
        if (bus_valid) begin
          vcnt++;
          total_cnt++;
          if (bus_addr !== exp_baddr || bus_strb !== exp_strb || bus_we !== op_we)
            $display("FAIL %s bus_fields: got addr=%h strb=%b we=%b want addr=%h strb=%b we=%b",
                     name, bus_addr, bus_strb, bus_we, exp_baddr, exp_strb, op_we);
          else pass_cnt++;
          if (op_we) begin
            total_cnt++;
            if (bus_wdata !== exp_bwdata) $display("FAIL %s bus_wdata: got %h want %h", name, bus_wdata, exp_bwdata);
            else pass_cnt++;
          end
          bus_ready = (vcnt - 1 == ready_wait);
          hs = bus_ready;
        end else begin
          bus_ready = 1'b0;
        end
        if (in_rd) begin
          rcnt++;
          bus_rvalid = (rcnt - 1 == rvalid_wait);
          bus_rdata = bus_rvalid ? rd_word : 32'hBAD0_BAD0;
        end
      end
    end
    if (!fin) begin
      total_cnt++;
      $display("FAIL %s completion: got no o_done in %0d cycles want done", name, cyc);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic idle_cycles(input int n);
    req = 1'b0;
    repeat (n) begin
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b0 || bus_valid !== 1'b0 || stall !== 1'b0)
        $display("FAIL idle: got done=%b valid=%b stall=%b want 0 0 0", done, bus_valid, stall);
      else pass_cnt++;
    end
  endtask

  task automatic check_zero_outputs(input string name);
    total_cnt++;
    if ({done, err, rdata, bus_valid, bus_we, bus_addr, bus_wdata, bus_strb} !== '0)
      $display("FAIL %s outputs: got done=%b err=%b rdata=%h valid=%b we=%b addr=%h wdata=%h strb=%b want all 0",
               name, done, err, rdata, bus_valid, bus_we, bus_addr, bus_wdata, bus_strb);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #3;
    check_zero_outputs("reset_async");
    repeat (2) @(negedge clk);
    check_zero_outputs("reset_held");
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL reset stall: got %b want 0", stall);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_store();
    run_op("sw",  1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 1, 2, 2'b00, 0);
    idle_cycles(1);
    run_op("sb",  1, 3'b000, 32'h1000_0003, 32'h0000_00A5, 0, 0, 0, 4'b1000, 32'hA5A5_A5A5, 1, 2, 2'b00, 0);
    idle_cycles(1);
    run_op("sh",  1, 3'b001, 32'h1000_0002, 32'h1234_BEEF, 0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 1, 2, 2'b00, 0);
    idle_cycles(1);
    run_op("sb0", 1, 3'b000, 32'h1000_0000, 32'h0000_003C, 1, 0, 0, 4'b0001, 32'h3C3C_3C3C, 2, 3, 2'b00, 0);
    idle_cycles(1);
  endtask

  task automatic test_load();
    run_op("lb",     0, 3'b000, 32'h2000_0001, 0, 0, 0, 32'h1234_8000, 4'b0000, 0, 1, 3, 2'b00, 32'hFFFF_FF80);
    idle_cycles(1);
    run_op("lbu",    0, 3'b100, 32'h2000_0001, 0, 0, 0, 32'h1234_8000, 4'b0000, 0, 1, 3, 2'b00, 32'h0000_0080);
    idle_cycles(1);
    run_op("lh_hi",  0, 3'b001, 32'h2000_0002, 0, 0, 0, 32'h1234_8000, 4'b0000, 0, 1, 3, 2'b00, 32'h0000_1234);
    idle_cycles(1);
    run_op("lh_lo",  0, 3'b001, 32'h2000_0000, 0, 0, 0, 32'h1234_8000, 4'b0000, 0, 1, 3, 2'b00, 32'hFFFF_8000);
    idle_cycles(1);
    run_op("lhu_lo", 0, 3'b101, 32'h2000_0000, 0, 0, 0, 32'h1234_8000, 4'b0000, 0, 1, 3, 2'b00, 32'h0000_8000);
    idle_cycles(1);
    run_op("lb3_rw", 0, 3'b000, 32'h2000_0003, 0, 0, 2, 32'h1234_8000, 4'b0000, 0, 1, 5, 2'b00, 32'h0000_0012);
    idle_cycles(1);
    run_op("lw_w1",  0, 3'b010, 32'h2000_0008, 0, 1, 0, 32'h1234_8000, 4'b0000, 0, 2, 4, 2'b00, 32'h1234_8000);
    idle_cycles(2);
    total_cnt++;
    if (rdata !== 32'h1234_8000) $display("FAIL rdata_hold: got %h want 12348000", rdata);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    run_op("lw_mis",   0, 3'b010, 32'h3000_0002, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 2'b01, 0);
    idle_cycles(1);
    run_op("ld_f3_7",  0, 3'b111, 32'h3000_0000, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 2'b10, 0);
    idle_cycles(1);
    run_op("st_f3_3",  1, 3'b011, 32'h3000_0001, 32'h1111_1111, 0, 0, 0, 4'b0000, 0, 0, 1, 2'b10, 0);
    idle_cycles(1);
    run_op("sh_mis",   1, 3'b001, 32'h3000_0001, 32'h2222_2222, 0, 0, 0, 4'b0000, 0, 0, 1, 2'b01, 0);
    idle_cycles(1);
    run_op("lh_mis",   0, 3'b001, 32'h3000_0003, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 2'b01, 0);
    idle_cycles(1);
  endtask

  task automatic test_timeout();
    run_op("sw_tmo",   1, 3'b010, 32'h4000_0010, 32'hCAFE_F00D, 100, 0, 0, 4'b1111, 32'hCAFE_F00D, 4, 5, 2'b11, 0);
    idle_cycles(1);
    run_op("sw_rdy4",  1, 3'b010, 32'h4000_0010, 32'hCAFE_F00D, 3, 0, 0, 4'b1111, 32'hCAFE_F00D, 4, 5, 2'b00, 0);
    idle_cycles(1);
    run_op("lw_prime", 0, 3'b010, 32'h4000_0020, 0, 0, 0, 32'h5555_AAAA, 4'b0000, 0, 1, 3, 2'b00, 32'h5555_AAAA);
    idle_cycles(1);
    run_op("lw_rtmo",  0, 3'b010, 32'h4000_0020, 0, 0, 100, 32'h5555_AAAA, 4'b0000, 0, 1, 6, 2'b11, 0);
    idle_cycles(1);
    run_op("lw_rv4",   0, 3'b010, 32'h4000_0024, 0, 0, 3, 32'h0BAD_F00D, 4'b0000, 0, 1, 6, 2'b00, 32'h0BAD_F00D);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_sw", 1, 3'b010, 32'h5000_0000, 32'h0102_0304, 0, 0, 0, 4'b1111, 32'h0102_0304, 1, 2, 2'b00, 0);
    run_op("b2b_lb", 0, 3'b000, 32'h5000_0002, 0, 0, 0, 32'h00F0_0000, 4'b0000, 0, 1, 3, 2'b00, 32'hFFFF_FFF0);
    run_op("b2b_er", 0, 3'b110, 32'h5000_0000, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 2'b10, 0);
    run_op("b2b_sh", 1, 3'b001, 32'h5000_0000, 32'h0000_7E57, 0, 0, 0, 4'b0011, 32'h7E57_7E57, 1, 2, 2'b00, 0);
    idle_cycles(1);
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h6000_0100; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus_valid !== 1'b1) $display("FAIL mid_reset addr_phase: got valid=%b want 1", bus_valid);
    else pass_cnt++;
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    total_cnt++;
    if (stall !== 1'b1 || bus_valid !== 1'b0) $display("FAIL mid_reset rdata_phase: got stall=%b valid=%b want 1 0", stall, bus_valid);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn mid_reset     released");
    run_op("sw_after", 1, 3'b010, 32'h6000_0200, 32'h600D_CAFE, 0, 0, 0, 4'b1111, 32'h600D_CAFE, 1, 2, 2'b00, 0);
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
